sram_like_arbiter: RTL and testbench

- Merges the CPU core's instruction-fetch and data-access SRAM-like master ports onto one shared SRAM-like slave port, so both can reach a single memory or bus bridge.
- Sits directly downstream of the core's inst/data memory interfaces, between the core and the memory or AXI bridge.
- Issues requests with fixed data-over-instruction priority and holds the grant stable while a request waits for acceptance.
- Returns responses to the issuing master in order, using a source-tracking FIFO.

---
 rtl/sram_like_arbiter.sv | 114 +++++++++++
 tb/tb_sram_like_arbiter.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/sram_like_arbiter.sv
// Merges instruction-fetch and data-access SRAM-like masters onto one slave port.
// Data has fixed priority. A source FIFO routes the in-order responses back to the issuing master.
module sram_like_arbiter #(
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [3:0]  inst_wstrb,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata,
  output logic        proto_err
);

  localparam int PTR_W = $clog2(MAX_OUTSTANDING);
  localparam int CNT_W = PTR_W + 1;

  logic             lock_valid_reg;
  logic             lock_src_reg;
  logic             src_mem_reg [MAX_OUTSTANDING];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;
  logic             proto_err_reg;

  logic grant_data;
  logic src_req;
  logic fifo_full;
  logic fifo_empty;
  logic push;
  logic pop;
  logic head;

  // A stalled request keeps its source so the slave sees stable fields until accepted.
  assign grant_data = lock_valid_reg ? lock_src_reg : data_req;
  assign src_req    = grant_data ? data_req : inst_req;
  assign fifo_full  = (count_reg == CNT_W'(MAX_OUTSTANDING));
  assign fifo_empty = (count_reg == '0);
  assign mem_req    = src_req & ~fifo_full & ~reset;
  assign push       = mem_req & mem_addr_ok;
  assign pop        = mem_data_ok & ~fifo_empty & ~reset;
  assign head       = src_mem_reg[rd_ptr_reg];

  assign mem_wr    = grant_data ? data_wr    : inst_wr;
  assign mem_size  = grant_data ? data_size  : inst_size;
  assign mem_addr  = grant_data ? data_addr  : inst_addr;
  assign mem_wstrb = grant_data ? data_wstrb : inst_wstrb;
  assign mem_wdata = grant_data ? data_wdata : inst_wdata;

  assign inst_addr_ok = push & ~grant_data;
  assign data_addr_ok = push & grant_data;
  assign inst_data_ok = pop & ~head;
  assign data_data_ok = pop & head;
  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;
  assign proto_err    = proto_err_reg;

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + CNT_W'(1);
      2'b01:   count_next = count_reg - CNT_W'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lock_valid_reg <= 1'b0;
      lock_src_reg   <= 1'b0;
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      count_reg      <= '0;
      proto_err_reg  <= 1'b0;
    end else begin
      // Locks only while a live request waits; a dropped req also clears it here.
      lock_valid_reg <= mem_req & ~mem_addr_ok;
      lock_src_reg   <= grant_data;
      count_reg      <= count_next;
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      if (mem_data_ok & fifo_empty) proto_err_reg <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) src_mem_reg[wr_ptr_reg] <= grant_data;
  end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Random and directed stimulus against a queue-based model of the arbiter.
// Inputs are driven at negedge and outputs are compared 1 ns later.
module tb_sram_like_arbiter;

  localparam int MAXO = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        inst_req = 1'b0, inst_wr = 1'b0;
  logic [1:0]  inst_size = '0;
  logic [31:0] inst_addr = '0, inst_wdata = '0;
  logic [3:0]  inst_wstrb = '0;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req = 1'b0, data_wr = 1'b0;
  logic [1:0]  data_size = '0;
  logic [31:0] data_addr = '0, data_wdata = '0;
  logic [3:0]  data_wstrb = '0;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        mem_req, mem_wr;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_addr_ok = 1'b0, mem_data_ok = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        proto_err;

  sram_like_arbiter #(.MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
    .inst_wstrb(inst_wstrb), .inst_wdata(inst_wdata),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wstrb(data_wstrb), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_addr(mem_addr),
    .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
    .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  bit keep_fields = 1'b0;

  // Reference model: outstanding sources in issue order, plus the pending-request lock.
  bit src_q[$];
  bit locked = 1'b0;
  bit locked_src = 1'b0;
  bit perr = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  task automatic drive_cycle(input bit rst, input bit ir, input bit dr, input bit aok, input bit dok);
    bit g, req_g, e_req, e_hs, e_pop, e_head;
    @(negedge clk);
    reset = rst; inst_req = ir; data_req = dr; mem_addr_ok = aok; mem_data_ok = dok;
    if (!keep_fields) begin
      inst_wr = 1'($urandom); inst_size = 2'($urandom_range(2)); inst_addr = $urandom;
      inst_wstrb = 4'($urandom); inst_wdata = $urandom;
      data_wr = 1'($urandom); data_size = 2'($urandom_range(2)); data_addr = $urandom;
      data_wstrb = 4'($urandom); data_wdata = $urandom;
    end
    mem_rdata = $urandom;
    #1;
    g      = locked ? locked_src : dr;
    req_g  = g ? dr : ir;
    e_req  = !rst && req_g && (src_q.size() < MAXO);
    e_hs   = e_req && aok;
    e_pop  = !rst && dok && (src_q.size() > 0);
    e_head = (src_q.size() > 0) ? src_q[0] : 1'b0;
    check_eq("mem_req", 32'(mem_req), 32'(e_req));
    check_eq("inst_addr_ok", 32'(inst_addr_ok), 32'(e_hs && !g));
    check_eq("data_addr_ok", 32'(data_addr_ok), 32'(e_hs && g));
    check_eq("inst_data_ok", 32'(inst_data_ok), 32'(e_pop && !e_head));
    check_eq("data_data_ok", 32'(data_data_ok), 32'(e_pop && e_head));
    check_eq("proto_err", 32'(proto_err), 32'(perr));
    if (e_req) begin
      check_eq("mem_addr",  mem_addr,          g ? data_addr : inst_addr);
      check_eq("mem_wr",    32'(mem_wr),       32'(g ? data_wr : inst_wr));
      check_eq("mem_size",  32'(mem_size),     32'(g ? data_size : inst_size));
      check_eq("mem_wstrb", 32'(mem_wstrb),    32'(g ? data_wstrb : inst_wstrb));
      check_eq("mem_wdata", mem_wdata,         g ? data_wdata : inst_wdata);
    end
    if (e_pop) begin
      if (e_head) check_eq("data_rdata", data_rdata, mem_rdata);
      else        check_eq("inst_rdata", inst_rdata, mem_rdata);
    end
    @(posedge clk);
    cyc++;
    if (rst) begin
      src_q.delete();
      locked = 1'b0;
      perr = 1'b0;
    end else begin
      if (dok && src_q.size() == 0) perr = 1'b1;
      if (e_pop) void'(src_q.pop_front());
      if (e_hs) src_q.push_back(g);
      locked = e_req && !aok;
      locked_src = g;
    end
  endtask

  initial begin
    int p_aok, p_dok, p_req;
    // Reset state
    drive_cycle(1, 0, 0, 0, 0);
    drive_cycle(1, 1, 1, 1, 1);
    // Simultaneous requests: data wins, then inst
    drive_cycle(0, 1, 1, 1, 0);
    drive_cycle(0, 1, 0, 1, 0);
    drive_cycle(0, 0, 0, 0, 1);
    drive_cycle(0, 0, 0, 0, 1);
    // Grant lock on inst while data arrives, fields held
    keep_fields = 1'b1;
    inst_addr = 32'h1C00_0000;
    data_addr = 32'h1C00_0100;
    drive_cycle(0, 1, 0, 0, 0);
    drive_cycle(0, 1, 1, 0, 0);
    drive_cycle(0, 1, 1, 0, 0);
    drive_cycle(0, 1, 1, 1, 0);
    drive_cycle(0, 0, 1, 1, 0);
    keep_fields = 1'b0;
    // Drain, then inst/data/inst in-order routing
    drive_cycle(0, 0, 0, 0, 1);
    drive_cycle(0, 0, 0, 0, 1);
    drive_cycle(0, 1, 0, 1, 0);
    drive_cycle(0, 0, 1, 1, 0);
    drive_cycle(0, 1, 0, 1, 0);
    for (int i = 0; i < 3; i++) drive_cycle(0, 0, 0, 0, 1);
    // Fill to full, blocked while full, one response frees a slot
    for (int i = 0; i < 4; i++) drive_cycle(0, 1, 1, 1, 0);
    drive_cycle(0, 1, 1, 1, 0);
    drive_cycle(0, 1, 1, 1, 1);
    drive_cycle(0, 1, 1, 1, 0);
    // Push and pop together at count=2 across pointer wrap
    drive_cycle(0, 0, 0, 0, 1);
    drive_cycle(0, 0, 0, 0, 1);
    for (int i = 0; i < 6; i++) drive_cycle(0, i[0], !i[0], 1, 1);
    for (int i = 0; i < 2; i++) drive_cycle(0, 0, 0, 0, 1);
    // Protocol error on empty, reset with outstanding work, then stray response
    drive_cycle(0, 0, 0, 0, 1);
    drive_cycle(0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) drive_cycle(0, 1, 0, 1, 0);
    drive_cycle(1, 0, 0, 0, 0);
    drive_cycle(0, 0, 0, 0, 0);
    drive_cycle(0, 0, 0, 0, 1);
    drive_cycle(0, 0, 0, 0, 0);
    drive_cycle(1, 0, 0, 0, 0);
    // Random phases: balanced, slow slave (fills FIFO), fast slave (empties it)
    for (int ph = 0; ph < 3; ph++) begin
      p_aok = (ph == 1) ? 80 : 50;
      p_dok = (ph == 0) ? 45 : ((ph == 1) ? 12 : 90);
      p_req = (ph == 2) ? 40 : 70;
      for (int i = 0; i < 1500; i++) begin
        drive_cycle($urandom_range(199) == 0,
                    $urandom_range(99) < p_req, $urandom_range(99) < p_req,
                    $urandom_range(99) < p_aok, $urandom_range(99) < p_dok);
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
